// File: rtl/edic_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, sequencer states,
// instruction field positions and the bundle of datapath control strobes.
package edic_ctrl_pkg;

  // 3-bit opcode in instruction bits [15:13]; 101..111 are undefined.
  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LDI   = 3'b001,
    OP_ALUI  = 3'b010,
    OP_STORE = 3'b011,
    OP_LOAD  = 3'b100,
    OP_ILL5  = 3'b101,
    OP_ILL6  = 3'b110,
    OP_ILL7  = 3'b111
  } opcode_t;

  // Sequencer steps; S1 is always the cycle after the accept edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } seq_state_t;

  // ALU operation encoding understood by the datapath.
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  // Instruction bit-field positions.
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int RD_BIT   = 12;
  localparam int RS_BIT   = 11;
  localparam int ALUOP_HI = 10;
  localparam int ALUOP_LO = 9;
  localparam int SHL_BIT  = 8;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  // Every registered output of the sequencer except ready/busy.
  typedef struct packed {
    logic [7:0] bus_override;
    logic       bus_override_en;
    logic       reg_wr0;
    logic       reg_wr1;
    logic       reg_bus_sel;
    logic       reg_bus_en;
    logic       alu_b_wr;
    logic [1:0] alu_op;
    logic       alu_shift_left;
    logic       alu_oe;
    logic       ram_address_en;
    logic       ram_write_en;
    logic       ram_oe;
    logic       ram_read_data_select;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer.sv
// Micro-sequencer that turns one 16-bit instruction into the per-cycle
// strobe pattern the datapath needs.
//
// Handshake: an instruction transfers on a rising edge where
// i_instrValid && o_instrReady; o_instrReady is high only in IDLE and never
// during reset, and i_instr is ignored on every other edge.
//
// Strobes are registered: the decode below looks at the *next* state and the
// *next* latched instruction, so the flops hold exactly the Moore outputs of
// the state being entered. Reset clears those flops asynchronously, which
// drops every strobe the moment reset rises.
module control_sequencer
  import edic_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_instr,
  input  logic        i_instrValid,
  output logic        o_instrReady,
  output logic        o_busy,
  output logic        o_illegal,
  output logic [7:0]  o_busOverride,
  output logic        o_busOverrideEn,
  output logic        o_ctrlRegWr0,
  output logic        o_ctrlRegWr1,
  output logic        o_ctrlRegBusSel,
  output logic        o_ctrlRegBusEn,
  output logic        o_ctrlAluBWr,
  output logic [1:0]  o_ctrlAluOp,
  output logic        o_ctrlAluShiftLeft,
  output logic        o_ctrlAluOE,
  output logic        o_ctrlRamAddressEn,
  output logic        o_ctrlRamWriteEn,
  output logic        o_ctrlRamOE,
  output logic        o_ctrlRamReadDataSelect
);

  seq_state_t  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  ctrl_t       ctrl_q, ctrl_d;

  opcode_t     cur_op;
  opcode_t     nxt_op;
  logic        nxt_rd;
  logic        nxt_rs;

  // Next-state / latch selection, then strobe decode of the state being entered.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ctrl_d  = '0;
    cur_op  = opcode_t'(instr_q[OPC_HI:OPC_LO]);

    case (state_q)
      ST_IDLE: begin
        if (i_instrValid) begin
          state_d = ST_S1;
          instr_d = i_instr;
        end
      end
      ST_S1: begin
        if (cur_op == OP_ALUI || cur_op == OP_STORE || cur_op == OP_LOAD) begin
          state_d = ST_S2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_S2: begin
        state_d = (cur_op == OP_ALUI) ? ST_S3 : ST_IDLE;
      end
      ST_S3: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    nxt_op = opcode_t'(instr_d[OPC_HI:OPC_LO]);
    nxt_rd = instr_d[RD_BIT];
    nxt_rs = instr_d[RS_BIT];

    case (state_d)
      ST_S1: begin
        case (nxt_op)
          OP_LDI: begin
            ctrl_d.bus_override_en = 1'b1;
            ctrl_d.bus_override    = instr_d[IMM_HI:IMM_LO];
            ctrl_d.reg_wr0         = ~nxt_rd;
            ctrl_d.reg_wr1         = nxt_rd;
          end
          OP_ALUI: begin
            ctrl_d.bus_override_en = 1'b1;
            ctrl_d.bus_override    = instr_d[IMM_HI:IMM_LO];
            ctrl_d.alu_b_wr        = 1'b1;
          end
          OP_STORE, OP_LOAD: begin
            ctrl_d.reg_bus_sel    = nxt_rs;
            ctrl_d.reg_bus_en     = 1'b1;
            ctrl_d.ram_address_en = 1'b1;
          end
          OP_ILL5, OP_ILL6, OP_ILL7: begin
            ctrl_d.illegal = 1'b1;
          end
          default: begin
            ctrl_d = '0;
          end
        endcase
      end
      ST_S2: begin
        case (nxt_op)
          OP_ALUI: begin
            ctrl_d.alu_op         = instr_d[ALUOP_HI:ALUOP_LO];
            ctrl_d.alu_shift_left = instr_d[SHL_BIT];
          end
          OP_STORE: begin
            ctrl_d.reg_bus_sel  = nxt_rd;
            ctrl_d.reg_bus_en   = 1'b1;
            ctrl_d.ram_write_en = 1'b1;
          end
          OP_LOAD: begin
            ctrl_d.ram_read_data_select = 1'b1;
            ctrl_d.ram_oe               = 1'b1;
            ctrl_d.reg_wr0              = ~nxt_rd;
            ctrl_d.reg_wr1              = nxt_rd;
          end
          default: begin
            ctrl_d = '0;
          end
        endcase
      end
      ST_S3: begin
        if (nxt_op == OP_ALUI) begin
          ctrl_d.alu_op         = instr_d[ALUOP_HI:ALUOP_LO];
          ctrl_d.alu_shift_left = instr_d[SHL_BIT];
          ctrl_d.alu_oe         = 1'b1;
          ctrl_d.reg_wr0        = ~nxt_rd;
          ctrl_d.reg_wr1        = nxt_rd;
        end
      end
      default: begin
        ctrl_d = '0;
      end
    endcase
  end

  // State, latched instruction and registered strobes; reset abandons any instruction.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign o_instrReady            = (state_q == ST_IDLE) & ~i_reset;
  assign o_busy                  = (state_q != ST_IDLE);
  assign o_illegal               = ctrl_q.illegal;
  assign o_busOverride           = ctrl_q.bus_override;
  assign o_busOverrideEn         = ctrl_q.bus_override_en;
  assign o_ctrlRegWr0            = ctrl_q.reg_wr0;
  assign o_ctrlRegWr1            = ctrl_q.reg_wr1;
  assign o_ctrlRegBusSel         = ctrl_q.reg_bus_sel;
  assign o_ctrlRegBusEn          = ctrl_q.reg_bus_en;
  assign o_ctrlAluBWr            = ctrl_q.alu_b_wr;
  assign o_ctrlAluOp             = ctrl_q.alu_op;
  assign o_ctrlAluShiftLeft      = ctrl_q.alu_shift_left;
  assign o_ctrlAluOE             = ctrl_q.alu_oe;
  assign o_ctrlRamAddressEn      = ctrl_q.ram_address_en;
  assign o_ctrlRamWriteEn        = ctrl_q.ram_write_en;
  assign o_ctrlRamOE             = ctrl_q.ram_oe;
  assign o_ctrlRamReadDataSelect = ctrl_q.ram_read_data_select;

endmodule
